// File: rtl/fft_twiddle_stage.sv
// Twiddle side of one radix-2 SDF FFT stage: ROM addressing plus rounded, saturating complex multiply.
// Fixed 3-cycle latency; no backpressure, so input gaps pass through as output gaps.
module fft_twiddle_stage #(
   parameter int DATA_WIDTH      = 16,
   parameter int TW_BIT_WIDTH    = 8,
   parameter int N_FFT           = 256,
   parameter int NO_STAGE        = 0,
   parameter int BANK_DEPTH      = N_FFT / (1 << (NO_STAGE + 1)),
   parameter int BANK_ADDR_WIDTH = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic                              in_sof,
   input  logic signed [DATA_WIDTH-1:0]      in_re,
   input  logic signed [DATA_WIDTH-1:0]      in_im,
   output logic                              tw_ren,
   output logic        [BANK_ADDR_WIDTH-1:0] tw_addr,
   input  logic signed [TW_BIT_WIDTH-1:0]    tw_re,
   input  logic signed [TW_BIT_WIDTH-1:0]    tw_im,
   output logic                              out_valid,
   output logic                              out_sof,
   output logic signed [DATA_WIDTH-1:0]      out_re,
   output logic signed [DATA_WIDTH-1:0]      out_im
);

   localparam int CW    = BANK_ADDR_WIDTH + 1;
   localparam int PW    = DATA_WIDTH + TW_BIT_WIDTH + 1;
   localparam int FRAC  = TW_BIT_WIDTH - 2;
   localparam int RND_I = 1 << (FRAC - 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(2 * BANK_DEPTH - 1);
   localparam logic [CW-1:0] HALF_IDX = CW'(BANK_DEPTH);
   localparam logic signed [PW-1:0] MAX_V = PW'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] MIN_V = PW'(-(1 << (DATA_WIDTH - 1)));

   logic [CW-1:0] cnt_q, cnt_d, idx;
   logic          mul_now;

   logic                         v1_q, v1_d, sof1_q, sof1_d, mul1_q, mul1_d;
   logic signed [DATA_WIDTH-1:0] re1_q, re1_d, im1_q, im1_d;
   logic                         v2_q, v2_d, sof2_q, sof2_d;
   logic signed [PW-1:0]         p_re_q, p_re_d, p_im_q, p_im_d;
   logic                         out_valid_q, out_valid_d, out_sof_q, out_sof_d;
   logic signed [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
   logic signed [PW-1:0]         ac, bd, ad, bc;

   function automatic logic signed [DATA_WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = (p + PW'(RND_I)) >>> FRAC;
      if (r > MAX_V)      return MAX_V[DATA_WIDTH-1:0];
      else if (r < MIN_V) return MIN_V[DATA_WIDTH-1:0];
      else                return r[DATA_WIDTH-1:0];
   endfunction

   // A frame start realigns the block position regardless of where the counter stood.
   always_comb begin
      idx     = in_sof ? '0 : cnt_q;
      mul_now = (idx >= HALF_IDX);
      cnt_d   = cnt_q;
      if (in_valid) cnt_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      tw_ren  = rst_n & in_valid & mul_now;
      tw_addr = '0;
      if (BANK_DEPTH > 1 && tw_ren) tw_addr = idx[BANK_ADDR_WIDTH-1:0];
   end

   always_comb begin
      v1_d   = in_valid;
      sof1_d = in_valid & in_sof;
      mul1_d = mul_now;
      re1_d  = in_re;
      im1_d  = in_im;

      ac = PW'(re1_q) * PW'(tw_re);
      bd = PW'(im1_q) * PW'(tw_im);
      ad = PW'(re1_q) * PW'(tw_im);
      bc = PW'(im1_q) * PW'(tw_re);
      v2_d   = v1_q;
      sof2_d = sof1_q;
      // Bypass samples are scaled by exactly 1.0 so the shared rounding stage returns them unchanged.
      if (mul1_q) begin
         p_re_d = ac - bd;
         p_im_d = ad + bc;
      end else begin
         p_re_d = PW'(re1_q) <<< FRAC;
         p_im_d = PW'(im1_q) <<< FRAC;
      end

      out_valid_d = v2_q;
      out_sof_d   = v2_q & sof2_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      if (v2_q) begin
         out_re_d = rnd_sat(p_re_q);
         out_im_d = rnd_sat(p_im_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         v1_q        <= 1'b0;
         sof1_q      <= 1'b0;
         mul1_q      <= 1'b0;
         re1_q       <= '0;
         im1_q       <= '0;
         v2_q        <= 1'b0;
         sof2_q      <= 1'b0;
         p_re_q      <= '0;
         p_im_q      <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         v1_q        <= v1_d;
         sof1_q      <= sof1_d;
         mul1_q      <= mul1_d;
         re1_q       <= re1_d;
         im1_q       <= im1_d;
         v2_q        <= v2_d;
         sof2_q      <= sof2_d;
         p_re_q      <= p_re_d;
         p_im_q      <= p_im_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft_twiddle_stage.sv
// Bench for fft_twiddle_stage: random streams against a sample-level model, with a few literal pins.
module tb_fft_twiddle_stage;

   typedef struct {
      int due;
      bit sof;
      int re;
      int im;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_sof = 1'b0;
   logic signed [15:0] in_re = '0;
   logic signed [15:0] in_im = '0;
   logic               tw_ren;
   logic [6:0]         tw_addr;
   logic signed [7:0]  tw_re = '0;
   logic signed [7:0]  tw_im = '0;
   logic               out_valid;
   logic               out_sof;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;

   logic signed [7:0]  rom_re [128];
   logic signed [7:0]  rom_im [128];

   int   cyc = 0;
   bit   rst_seen = 1'b0;
   int   mcnt = 0;
   bit   exp_ren = 1'b0;
   int   exp_addr = 0;
   int   last_re = 0;
   int   last_im = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];
   exp_t lq[$];

   fft_twiddle_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .in_re(in_re), .in_im(in_im), .tw_ren(tw_ren), .tw_addr(tw_addr),
      .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_sof(out_sof),
      .out_re(out_re), .out_im(out_im)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !rst_n;
      if (tw_ren) begin
         tw_re <= rom_re[tw_addr];
         tw_im <= rom_im[tw_addr];
      end
   end

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Q1.6 product back to 16 bits: round half up, then clamp.
   function automatic int rs(input longint p);
      longint r;
      r = (p + 64'sd32) >>> 6;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   function automatic int rnd16();
      logic [31:0] r;
      r = $urandom;
      return int'($signed(r[15:0]));
   endfunction

   task automatic drive(input bit v, input bit s, input int re, input int im);
      int   idx, c, d;
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
      in_re    = 16'(re);
      in_im    = 16'(im);
      exp_ren  = 1'b0;
      if (v) begin
         idx   = s ? 0 : mcnt;
         mcnt  = (idx + 1) % 256;
         e.due = cyc + 3;
         e.sof = s;
         if (idx >= 128) begin
            exp_ren  = 1'b1;
            exp_addr = idx - 128;
            c = rom_re[exp_addr];
            d = rom_im[exp_addr];
            e.re = rs(longint'(re) * c - longint'(im) * d);
            e.im = rs(longint'(re) * d + longint'(im) * c);
         end else begin
            e.re = re;
            e.im = im;
         end
         q.push_back(e);
      end
   endtask

   task automatic drive_lit(input int re, input int im, input int lre, input int lim);
      exp_t l;
      drive(1'b1, 1'b0, re, im);
      l.due = cyc + 3;
      l.sof = 1'b0;
      l.re  = lre;
      l.im  = lim;
      lq.push_back(l);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      exp_ren  = 1'b0;
      while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      while (lq.size() > 0 && lq[lq.size()-1].due > cyc) void'(lq.pop_back());
      mcnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (cyc > 0) begin
         if (rst_seen) begin
            last_re = 0;
            last_im = 0;
         end
         chk("tw_ren", int'(tw_ren), int'(exp_ren));
         if (exp_ren) chk("tw_addr", int'(tw_addr), exp_addr);
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", int'(out_valid), 1);
            chk("out_sof", int'(out_sof), int'(e.sof));
            chk("out_re", int'(out_re), e.re);
            chk("out_im", int'(out_im), e.im);
            last_re = e.re;
            last_im = e.im;
         end else begin
            chk("out_valid_idle", int'(out_valid), 0);
            chk("out_sof_idle", int'(out_sof), 0);
            chk("out_re_hold", int'(out_re), last_re);
            chk("out_im_hold", int'(out_im), last_im);
         end
         if (lq.size() > 0 && lq[0].due == cyc) begin
            e = lq.pop_front();
            chk("lit_valid", int'(out_valid), 1);
            chk("lit_re", int'(out_re), e.re);
            chk("lit_im", int'(out_im), e.im);
         end
      end
   end

   initial begin
      for (int i = 0; i < 128; i++) begin
         rom_re[i] = 8'($urandom);
         rom_im[i] = 8'($urandom);
      end
      rom_re[64] = 8'sd0;  rom_im[64] = -8'sd64;
      rom_re[32] = 8'sd45; rom_im[32] = -8'sd45;
      rom_re[72] = 8'sd0;  rom_im[72] = -8'sd64;

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // One full block, back to back, with directed samples at known positions.
      for (int i = 0; i < 256; i++) begin
         case (i)
            0:       drive(1'b1, 1'b1, rnd16(), rnd16());
            5:       drive_lit(-1234, 777, -1234, 777);
            160:     drive_lit(1, 0, 1, -1);
            192:     drive_lit(100, 50, 50, -100);
            200:     drive_lit(-32768, -32768, -32768, 32767);
            default: drive(1'b1, 1'b0, rnd16(), rnd16());
         endcase
      end

      // Random gaps across two blocks.
      drive(1'b1, 1'b1, rnd16(), rnd16());
      for (int i = 0; i < 600; i++)
         drive($urandom_range(0, 9) < 7, 1'b0, rnd16(), rnd16());

      // Frame start in the middle of a block.
      while (mcnt != 70) drive(1'b1, 1'b0, rnd16(), rnd16());
      drive(1'b1, 1'b1, rnd16(), rnd16());
      for (int i = 0; i < 200; i++) drive(1'b1, 1'b0, rnd16(), rnd16());

      // Reset with two samples in flight, then a stream without frame start.
      drive(1'b1, 1'b0, rnd16(), rnd16());
      drive(1'b1, 1'b0, rnd16(), rnd16());
      pulse_reset();
      for (int i = 0; i < 260; i++) drive(1'b1, 1'b0, rnd16(), rnd16());

      repeat (6) drive(1'b0, 1'b0, 0, 0);
      if (q.size() != 0 || lq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d outputs still expected, required 0", q.size() + lq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
